// File: rtl/bcd_to_bin_if.sv
// Request/result bundle for the packed-BCD to binary converter.
// The master drives en/bcd_d_in; the converter drives result and status.
interface bcd_to_bin_if #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
);
    logic                  en;
    logic [4*DIGITS-1:0]   bcd_d_in;
    logic [BIN_W-1:0]      bin_d_out;
    logic                  rdy;
    logic                  busy;
    logic                  err;

    modport master (
        output en, bcd_d_in,
        input  bin_d_out, rdy, busy, err
    );

    modport slave (
        input  en, bcd_d_in,
        output bin_d_out, rdy, busy, err
    );
endinterface

// File: rtl/bcd_to_bin.sv
// Iterative reverse double-dabble (shift right, subtract 3) packed-BCD to binary converter.
// Optional invalid-digit flagging is enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd_to_bin #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    bcd_to_bin_if.slave   bus
);
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned WORK_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ADJ,
        DONE
    } state_t;

    state_t              state, state_nxt;
    logic [WORK_W-1:0]   work, work_nxt;
    logic [CNT_W-1:0]    sh_cnt, sh_cnt_nxt;
    logic [BIN_W-1:0]    bin_q, bin_nxt;
    logic                rdy_q, rdy_nxt;

    // A nibble can only reach 8+ after a shift if a bit came in from above, so
    // subtracting 3 halves the decimal weight exactly, even for nibbles above 9.
    function automatic logic [WORK_W-1:0] adjust(input logic [WORK_W-1:0] w);
        logic [3:0] nib;
        adjust = w;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            nib = w[BIN_W + 4*i +: 4];
            if (nib >= 4'd8)
                adjust[BIN_W + 4*i +: 4] = nib - 4'd3;
        end
    endfunction

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic err_pend, err_pend_nxt;
    logic err_q, err_nxt;
    logic bad_digit;

    always_comb begin
        bad_digit = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bus.bcd_d_in[4*i +: 4] > 4'd9)
                bad_digit = 1'b1;
        end
    end
`endif

    always_comb begin
        state_nxt  = state;
        work_nxt   = work;
        sh_cnt_nxt = sh_cnt;
        bin_nxt    = bin_q;
        rdy_nxt    = 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        err_pend_nxt = err_pend;
        err_nxt      = err_q;
`endif
        case (state)
            IDLE: begin
                if (bus.en) begin
                    work_nxt   = {bus.bcd_d_in, {BIN_W{1'b0}}};
                    sh_cnt_nxt = '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    err_pend_nxt = bad_digit;
`endif
                    state_nxt  = SHIFT;
                end
            end
            SHIFT: begin
                work_nxt   = work >> 1;
                sh_cnt_nxt = sh_cnt + 1'b1;
                state_nxt  = (sh_cnt == CNT_W'(BIN_W - 1)) ? DONE : ADJ;
            end
            ADJ: begin
                work_nxt  = adjust(work);
                state_nxt = SHIFT;
            end
            DONE: begin
                bin_nxt = work[BIN_W-1:0];
`ifdef BCD2BIN_DIGIT_CHECK_EN
                err_nxt = err_pend;
                if (err_pend)
                    bin_nxt = '0;
`endif
                rdy_nxt   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            work   <= '0;
            sh_cnt <= '0;
            bin_q  <= '0;
            rdy_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            work   <= work_nxt;
            sh_cnt <= sh_cnt_nxt;
            bin_q  <= bin_nxt;
            rdy_q  <= rdy_nxt;
        end
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pend <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_pend <= err_pend_nxt;
            err_q    <= err_nxt;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.bin_d_out = bin_q;
    assign bus.rdy       = rdy_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: scoreboard of {err, value} popped on each rdy.
// Build with BCD2BIN_DIGIT_CHECK_EN defined to exercise invalid-digit flagging.
module tb_bcd_to_bin;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [14:0] exp_q[$];
    logic [14:0] mon_exp;

    bcd_to_bin_if #(.DIGITS(4), .BIN_W(14)) bus ();

    bcd_to_bin #(.DIGITS(4), .BIN_W(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Scoreboard: every rdy must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rdy: got rdy with bin_d_out=%0d err=%0b, required no rdy",
                         bus.bin_d_out, bus.err);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({bus.err, bus.bin_d_out} !== mon_exp) begin
                    errors++;
                    $display("FAIL result: got err=%0b bin_d_out=%0d, required err=%0b bin_d_out=%0d",
                             bus.err, bus.bin_d_out, mon_exp[14], mon_exp[13:0]);
                end
            end
        end
    end

    task automatic start(input logic [15:0] v);
        @(negedge clk);
        bus.bcd_d_in = v;
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
    endtask

    task automatic wait_rdy(input string name, output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        while (!bus.rdy && n < 100) begin
            if (bus.busy) busy_n++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.rdy) begin
            errors++;
            $display("FAIL %s_timeout: got no rdy after %0d cycles, required rdy within 100", name, n);
        end
    endtask

    task automatic check_rdy_low(input string name);
        @(negedge clk);
        checks++;
        if (bus.rdy !== 1'b0) begin
            errors++;
            $display("FAIL %s_rdy_width: got rdy=%b one cycle after pulse, required 0", name, bus.rdy);
        end
    endtask

    task automatic test_reset;
        bus.en = 1'b0;
        bus.bcd_d_in = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.bin_d_out, bus.rdy, bus.busy, bus.err} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got bin=%0d rdy=%b busy=%b err=%b, required all 0",
                     bus.bin_d_out, bus.rdy, bus.busy, bus.err);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got busy=%b without en, required 0", bus.busy);
        end
    endtask

    task automatic test_basic;
        int n, bn;
        exp_q.push_back({1'b0, 14'd1234});
        start(16'h1234);
        wait_rdy("basic", n, bn);
        checks++;
        if (n != 28) begin
            errors++;
            $display("FAIL basic_latency: got rdy %0d cycles after accept, required 28", n);
        end
        checks++;
        if (bn != 28) begin
            errors++;
            $display("FAIL basic_busy: got busy high for %0d cycles, required 28", bn);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_fall: got busy=%b with rdy, required 0", bus.busy);
        end
        check_rdy_low("basic");
        checks++;
        if (bus.bin_d_out !== 14'd1234) begin
            errors++;
            $display("FAIL basic_hold: got bin_d_out=%0d after rdy, required 1234", bus.bin_d_out);
        end
    endtask

    task automatic test_values;
        int n, bn;
        exp_q.push_back({1'b0, 14'h270F});
        start(16'h9999);
        wait_rdy("max", n, bn);
        check_rdy_low("max");
        exp_q.push_back({1'b0, 14'd0});
        start(16'h0000);
        wait_rdy("zero", n, bn);
        checks++;
        if (n != 28) begin
            errors++;
            $display("FAIL zero_latency: got rdy %0d cycles after accept, required 28", n);
        end
        check_rdy_low("zero");
    endtask

    task automatic test_ignore_en;
        int n, bn;
        exp_q.push_back({1'b0, 14'd255});
        start(16'h0255);
        repeat (4) @(negedge clk);
        bus.bcd_d_in = 16'h7777;
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        bus.bcd_d_in = 16'h0000;
        wait_rdy("ignore", n, bn);
        // Request at rdy+1: IDLE is re-entered on the rdy edge.
        bus.bcd_d_in = 16'h7777;
        bus.en = 1'b1;
        exp_q.push_back({1'b0, 14'd7777});
        @(negedge clk);
        bus.en = 1'b0;
        checks++;
        if (bus.rdy !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL rdy1_accept: got rdy=%b busy=%b, required rdy=0 busy=1", bus.rdy, bus.busy);
        end
        wait_rdy("rdy1", n, bn);
        checks++;
        if (n != 28) begin
            errors++;
            $display("FAIL rdy1_latency: got rdy %0d cycles after accept, required 28", n);
        end
        check_rdy_low("rdy1");
    endtask

    task automatic test_reset_mid;
        int n, bn;
        start(16'h4321);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.bin_d_out, bus.rdy, bus.busy, bus.err} !== 17'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got bin=%0d rdy=%b busy=%b err=%b, required all 0",
                     bus.bin_d_out, bus.rdy, bus.busy, bus.err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.bin_d_out !== 14'd0) begin
            errors++;
            $display("FAIL midreset_quiet: got busy=%b bin=%0d, required busy=0 bin=0",
                     bus.busy, bus.bin_d_out);
        end
        exp_q.push_back({1'b0, 14'd42});
        start(16'h0042);
        wait_rdy("after_reset", n, bn);
        checks++;
        if (n != 28) begin
            errors++;
            $display("FAIL after_reset_latency: got rdy %0d cycles after accept, required 28", n);
        end
        check_rdy_low("after_reset");
    endtask

    task automatic test_digit_check;
        int n, bn;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        exp_q.push_back({1'b1, 14'd0});
`else
        // 1*1000 + 2*100 + 10*10 + 4: invalid nibbles keep their positional weight.
        exp_q.push_back({1'b0, 14'd1304});
`endif
        start(16'h12A4);
        wait_rdy("digit_bad", n, bn);
        check_rdy_low("digit_bad");
        checks++;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        if (bus.err !== 1'b1) begin
            errors++;
            $display("FAIL err_hold: got err=%b after rdy, required 1", bus.err);
        end
`else
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL err_tied: got err=%b, required 0", bus.err);
        end
`endif
        exp_q.push_back({1'b0, 14'd10});
        start(16'h0010);
        wait_rdy("digit_good", n, bn);
        check_rdy_low("digit_good");
    endtask

    task automatic test_back_to_back;
        int n, bn;
        int t[3];
        @(negedge clk);
        bus.bcd_d_in = 16'h0001;
        bus.en = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 14'd1});
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            wait_rdy("b2b", n, bn);
            t[k] = cyc;
            if (k == 2) bus.en = 1'b0;
            @(negedge clk);
        end
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (t[k] - t[k-1] != 29) begin
                errors++;
                $display("FAIL b2b_spacing%0d: got %0d cycles between rdy pulses, required 29",
                         k, t[k] - t[k-1]);
            end
        end
        repeat (40) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_values;
        test_ignore_en;
        test_reset_mid;
        test_digit_check;
        test_back_to_back;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d results outstanding, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got simulation still running, required completion");
        $fatal(1);
    end
endmodule
